// File: rtl/mem_writeback_if.sv
// mem_writeback_if: data-memory request/acknowledge bus between the writeback stage and memory
interface mem_writeback_if;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemAck;
    logic [31:0] MemRData;

    modport master (
        output MemReq, MemWe, MemAddr, MemWData,
        input  MemAck, MemRData
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWData,
        output MemAck, MemRData
    );
endinterface

// File: rtl/mem_writeback.sv
// mem_writeback: M and W pipeline stages with a stalling data-memory handshake and timeout abort
module mem_writeback #(
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ValidE,
    input  logic                   RegWriteE,
    input  logic                   MemToRegE,
    input  logic                   MemWriteE,
    input  logic [3:0]             WA3E,
    input  logic [31:0]            ALUResultE,
    input  logic [31:0]            WriteDataE,
    mem_writeback_if.master        mem,
    output logic                   StallM,
    output logic                   RegWriteW,
    output logic [3:0]             WA3W,
    output logic [31:0]            ResultW,
    output logic                   PCSrcW,
    output logic                   MemError,
    output logic [31:0]            RetiredCount
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        m_valid_q, m_valid_d;
    logic        m_regwrite_q, m_regwrite_d;
    logic        m_memtoreg_q, m_memtoreg_d;
    logic        m_memwrite_q, m_memwrite_d;
    logic [3:0]  m_wa3_q, m_wa3_d;
    logic [31:0] m_alu_q, m_alu_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        w_valid_q, w_valid_d;
    logic        w_regwrite_q, w_regwrite_d;
    logic [3:0]  w_wa3_q, w_wa3_d;
    logic [31:0] w_result_q, w_result_d;
    logic        err_q, err_d;
    logic [31:0] retired_q, retired_d;
    logic        mem_op, ack, timeout, stall;

    assign mem_op  = m_valid_q & (m_memtoreg_q | m_memwrite_q);
    assign ack     = mem_op & mem.MemAck;
    assign timeout = (state_q == S_WAIT) && (cnt_q == CW'(TIMEOUT));
    assign stall   = mem_op & ~ack & ~timeout;

    assign mem.MemReq   = mem_op;
    assign mem.MemWe    = m_memwrite_q;
    assign mem.MemAddr  = m_alu_q;
    assign mem.MemWData = m_wdata_q;

    assign StallM       = stall;
    assign RegWriteW    = w_valid_q & w_regwrite_q;
    assign WA3W         = w_wa3_q;
    assign ResultW      = w_result_q;
    assign PCSrcW       = RegWriteW & (w_wa3_q == 4'd15);
    assign MemError     = err_q;
    assign RetiredCount = retired_q;

    // Next-state: handshake FSM, M hold/capture, W load or bubble, sticky error and retire count
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        if (state_q == S_IDLE) begin
            if (mem_op && !ack) begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
        end else if (ack || timeout) begin
            state_d = S_IDLE;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        m_valid_d    = stall ? m_valid_q    : ValidE;
        m_regwrite_d = stall ? m_regwrite_q : RegWriteE;
        m_memtoreg_d = stall ? m_memtoreg_q : MemToRegE;
        m_memwrite_d = stall ? m_memwrite_q : MemWriteE;
        m_wa3_d      = stall ? m_wa3_q      : WA3E;
        m_alu_d      = stall ? m_alu_q      : ALUResultE;
        m_wdata_d    = stall ? m_wdata_q    : WriteDataE;
        w_valid_d    = m_valid_q & ~stall & ~timeout;
        w_regwrite_d = stall ? w_regwrite_q : (m_regwrite_q & ~m_memwrite_q);
        w_wa3_d      = stall ? w_wa3_q      : m_wa3_q;
        w_result_d   = stall ? w_result_q   : (m_memtoreg_q ? mem.MemRData : m_alu_q);
        err_d        = err_q | timeout;
        retired_d    = retired_q + 32'(w_valid_d);
    end

    // State registers, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            m_valid_q    <= 1'b0;
            m_regwrite_q <= 1'b0;
            m_memtoreg_q <= 1'b0;
            m_memwrite_q <= 1'b0;
            m_wa3_q      <= '0;
            m_alu_q      <= '0;
            m_wdata_q    <= '0;
            w_valid_q    <= 1'b0;
            w_regwrite_q <= 1'b0;
            w_wa3_q      <= '0;
            w_result_q   <= '0;
            err_q        <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            m_valid_q    <= m_valid_d;
            m_regwrite_q <= m_regwrite_d;
            m_memtoreg_q <= m_memtoreg_d;
            m_memwrite_q <= m_memwrite_d;
            m_wa3_q      <= m_wa3_d;
            m_alu_q      <= m_alu_d;
            m_wdata_q    <= m_wdata_d;
            w_valid_q    <= w_valid_d;
            w_regwrite_q <= w_regwrite_d;
            w_wa3_q      <= w_wa3_d;
            w_result_q   <= w_result_d;
            err_q        <= err_d;
            retired_q    <= retired_d;
        end
    end
endmodule

// File: tb/tb_mem_writeback.sv
// tb_mem_writeback: directed vectors for the memory/writeback stage
module tb_mem_writeback;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ValidE = 1'b0, RegWriteE = 1'b0, MemToRegE = 1'b0, MemWriteE = 1'b0;
    logic [3:0]  WA3E = '0;
    logic [31:0] ALUResultE = '0, WriteDataE = '0;
    logic        StallM, RegWriteW, PCSrcW, MemError;
    logic [3:0]  WA3W;
    logic [31:0] ResultW, RetiredCount;
    int          n_cmp = 0;
    int          n_bad = 0;

    mem_writeback_if bus();

    mem_writeback #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
        .WA3E(WA3E), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .mem(bus),
        .StallM(StallM), .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW),
        .PCSrcW(PCSrcW), .MemError(MemError), .RetiredCount(RetiredCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic mw,
                         input logic [3:0] wa, input logic [31:0] alu, input logic [31:0] wd);
        ValidE = v; RegWriteE = rw; MemToRegE = m2r; MemWriteE = mw;
        WA3E = wa; ALUResultE = alu; WriteDataE = wd;
    endtask

    initial begin
        bus.MemAck = 1'b0;
        bus.MemRData = '0;
        tick(); tick();
        check("rst_req", bus.MemReq, 0);
        check("rst_stall", StallM, 0);
        check("rst_regw", RegWriteW, 0);
        check("rst_retired", RetiredCount, 0);
        reset = 1'b1;

        // ADD r3 = 0x10
        drive(1, 1, 0, 0, 3, 32'h10, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        check("add_req", bus.MemReq, 0);
        check("add_stall", StallM, 0);
        tick();
        check("add_regw", RegWriteW, 1);
        check("add_wa3", WA3W, 3);
        check("add_res", ResultW, 32'h10);
        check("add_cnt", RetiredCount, 1);
        check("add_pcsrc", PCSrcW, 0);

        // load r5 from 0x40, ack in third request cycle, ADD r6 held behind it
        drive(1, 1, 1, 0, 5, 32'h40, 0); tick();
        drive(1, 1, 0, 0, 6, 32'h66, 0); #1;
        check("ld_req", bus.MemReq, 1);
        check("ld_we", bus.MemWe, 0);
        check("ld_addr", bus.MemAddr, 32'h40);
        check("ld_stall1", StallM, 1);
        tick(); #1;
        check("ld_stall2", StallM, 1);
        check("ld_bubble", RegWriteW, 0);
        check("ld_cnt_hold", RetiredCount, 1);
        tick();
        bus.MemAck = 1'b1; bus.MemRData = 32'hDEADBEEF; #1;
        check("ld_release", StallM, 0);
        tick();
        bus.MemAck = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("ld_regw", RegWriteW, 1);
        check("ld_wa3", WA3W, 5);
        check("ld_res", ResultW, 32'hDEADBEEF);
        check("ld_cnt", RetiredCount, 2);
        tick();
        check("held_regw", RegWriteW, 1);
        check("held_wa3", WA3W, 6);
        check("held_res", ResultW, 32'h66);
        check("held_cnt", RetiredCount, 3);

        // store 0x1234 to 0x80 with immediate ack, RegWriteE set but must not write
        drive(1, 1, 0, 1, 7, 32'h80, 32'h1234); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        bus.MemAck = 1'b1; #1;
        check("st_req", bus.MemReq, 1);
        check("st_we", bus.MemWe, 1);
        check("st_addr", bus.MemAddr, 32'h80);
        check("st_wdata", bus.MemWData, 32'h1234);
        check("st_stall", StallM, 0);
        tick();
        check("st_regw", RegWriteW, 0);
        check("st_cnt", RetiredCount, 4);

        // stray ack with no request
        bus.MemRData = 32'h55AA55AA; #1;
        check("stray_stall", StallM, 0);
        tick();
        bus.MemAck = 1'b0;
        check("stray_regw", RegWriteW, 0);
        check("stray_cnt", RetiredCount, 4);

        // write r15 = 0x200
        drive(1, 1, 0, 0, 15, 32'h200, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        check("pc_regw", RegWriteW, 1);
        check("pc_src", PCSrcW, 1);
        check("pc_res", ResultW, 32'h200);
        check("pc_cnt", RetiredCount, 5);

        // load r8 with no ack: 1 idle + 4 wait cycles stalled, abort in the 5th wait cycle
        drive(1, 1, 1, 0, 8, 32'h44, 0); tick();
        drive(1, 1, 0, 0, 9, 32'h99, 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("to_stall%0d", k), StallM, 1);
            tick();
        end
        #1;
        check("to_release", StallM, 0);
        check("to_req_last", bus.MemReq, 1);
        check("to_err_pre", MemError, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("to_err", MemError, 1);
        check("to_drop", RegWriteW, 0);
        check("to_cnt", RetiredCount, 5);
        check("to_req_drop", bus.MemReq, 0);
        tick();
        check("to_add_regw", RegWriteW, 1);
        check("to_add_wa3", WA3W, 9);
        check("to_add_res", ResultW, 32'h99);
        check("to_add_cnt", RetiredCount, 6);
        check("to_err_sticky", MemError, 1);

        // reset pulsed mid-wait
        drive(1, 1, 1, 0, 10, 32'h48, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick(); #1;
        check("rw_stall", StallM, 1);
        reset = 1'b0; #1;
        check("rw_req", bus.MemReq, 0);
        check("rw_addr", bus.MemAddr, 0);
        check("rw_stall0", StallM, 0);
        check("rw_err", MemError, 0);
        check("rw_cnt", RetiredCount, 0);
        check("rw_res", ResultW, 0);
        check("rw_wa3", WA3W, 0);
        check("rw_pcsrc", PCSrcW, 0);
        tick(); tick();
        reset = 1'b1; #1;
        check("rw_post_req", bus.MemReq, 0);
        drive(1, 1, 1, 0, 11, 32'h4C, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        bus.MemAck = 1'b1; bus.MemRData = 32'hCAFEF00D; #1;
        check("rw_ld_stall", StallM, 0);
        tick();
        bus.MemAck = 1'b0;
        check("rw_ld_regw", RegWriteW, 1);
        check("rw_ld_wa3", WA3W, 11);
        check("rw_ld_res", ResultW, 32'hCAFEF00D);
        check("rw_ld_cnt", RetiredCount, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_writeback.md
MEM_WRITEBACK -- requirements
Module: mem_writeback

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, the max cycles waited for MemAck before abort.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-004 ValidE  input  1  the execute-stage outputs below carry a live instruction.
REQ-005 RegWriteE, MemToRegE, MemWriteE  input  1 each  register write, load, and store controls from execute.
REQ-006 WA3E  input  4  destination register index.
REQ-007 ALUResultE  input  32  ALU result, also the memory address.
REQ-008 WriteDataE  input  32  store data.
REQ-009 MemReq  output  1  request to data memory, level, held until MemAck.
REQ-010 MemWe  output  1  request is a store.
REQ-011 MemAddr, MemWData  output  32 each  request address and store data.
REQ-012 MemAck  input  1  one-cycle completion pulse; MemRData is valid in the same cycle.
REQ-013 MemRData  input  32  load data.
REQ-014 StallM  output  1  upstream SHALL hold its execute outputs while this is 1.
REQ-015 RegWriteW  output  1  register file write enable toward decode.
REQ-016 WA3W  output  4  register file write address.
REQ-017 ResultW  output  32  register file write data.
REQ-018 PCSrcW  output  1  the write targets r15 (branch by write).
REQ-019 MemError  output  1  sticky flag, set on memory timeout.
REQ-020 RetiredCount  output  32  count of instructions committed in W.

Function
REQ-021 The M register SHALL capture all E inputs on each clk edge where StallM=0, and SHALL hold its contents while StallM=1.
REQ-022 FSM states SHALL be IDLE and WAIT.
- IDLE->WAIT: M valid AND (MemToRegM OR MemWriteM) AND MemAck=0.
- WAIT->IDLE: MemAck=1 or timeout.
REQ-023 MemReq SHALL equal M valid AND (MemToRegM OR MemWriteM), combinationally, in both IDLE and WAIT.
- MemWe SHALL equal MemWriteM.
- MemAddr SHALL equal ALUResultM.
- MemWData SHALL equal WriteDataM.
REQ-024 StallM SHALL equal MemReq AND NOT MemAck AND NOT timeout; a same-cycle ack SHALL release the stall with zero extra cycles.
REQ-025 A wait counter SHALL clear on entering WAIT and increment by 1 each cycle in WAIT.
- Timeout SHALL be counter==TIMEOUT.
- On timeout: MemError<=1; the instruction is dropped (no W write); MemReq SHALL drop the following cycle.
REQ-026 The W register SHALL load on each edge where StallM=0 and SHALL receive a bubble (valid=0) while StallM=1.
- ResultW = MemRData if MemToRegM, else ALUResultM.
- A dropped (timed-out) instruction SHALL enter W as a bubble.
REQ-027 RegWriteW SHALL equal W valid AND RegWrite of W; WA3W and ResultW come from the W register.
REQ-028 PCSrcW SHALL equal RegWriteW AND (WA3W==15).
REQ-029 Latency SHALL be:
- non-memory instruction: ValidE accepted at edge n, RegWriteW high after edge n+1;
- load acked in first request cycle: same as non-memory;
- each extra wait cycle: +1.
REQ-030 Stores SHALL write no register even if RegWriteE=1.
REQ-031 RetiredCount SHALL increment by 1 on every edge where a valid instruction enters W, including stores and non-writing instructions, and SHALL wrap 0xFFFFFFFF->0.
REQ-032 MemAck arriving while MemReq=0 SHALL be ignored.

Reset
REQ-033 While reset=0 the following SHALL all be 0:
- M and W valid, state=IDLE, wait counter;
- MemReq, MemWe, MemAddr, MemWData;
- StallM, RegWriteW, WA3W, ResultW, PCSrcW;
- MemError, RetiredCount.
REQ-034 Reset asserted mid-WAIT SHALL abandon the transaction; after release the FSM SHALL be IDLE with MemReq=0.
REQ-035 MemError SHALL be cleared only by reset.

Verification
REQ-036 ADD with RegWriteE=1, WA3E=3, ALUResultE=0x10 -> one cycle later RegWriteW=1, WA3W=3, ResultW=0x10, RetiredCount=1.
REQ-037 Load to r5 at addr 0x40, MemAck after 3 request cycles with MemRData=0xDEADBEEF -> StallM=1 for 2 cycles, then RegWriteW=1, WA3W=5, ResultW=0xDEADBEEF; W holds bubbles during the stall.
REQ-038 Store of 0x1234 to 0x80 with immediate ack -> MemWe=1, MemWData=0x1234, StallM never asserted, RegWriteW stays 0, RetiredCount increments.
REQ-039 Write to r15 with 0x200 -> PCSrcW=1, ResultW=0x200.
REQ-040 Load with no MemAck, TIMEOUT=4 -> MemError=1 after 4 wait cycles, no register write, stall released, following ADD commits normally.
REQ-041 reset=0 pulsed mid-WAIT -> all outputs 0 asynchronously; after release a new load completes normally.
